// File: rtl/imem_responder.sv
// imem_responder: single-outstanding instruction fetch responder.
// A read is accepted in IDLE (or in RESP for back-to-back fetches). After a fixed
// LATENCY the word is presented for exactly one Done cycle. Stall tells the fetch
// stage to hold its PC while a read is in flight. A side write port preloads the
// program image and is honoured in every state.
module imem_responder #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Rd,
    input  logic [15:0] Addr,
    input  logic        Wr,
    input  logic [15:0] WrAddr,
    input  logic [15:0] WrData,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        Err
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned AW    = DEPTH_LOG2 + 1;
    // Countdown reload value; WAIT lasts LATENCY-1 cycles before RESP.
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    // Only the word-index bits plus the byte-odd bit of the PC are kept;
    // higher bits alias onto the same word.
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     mem_q [DEPTH];

    logic            in_idle_s;
    logic            in_wait_s;
    logic            in_resp_s;
    logic [15:0]     rd_word_s;

    // Address bits above the word index are deliberately ignored (wrap).
    logic            unused_addr_bits_s;
    assign unused_addr_bits_s = ^{Addr[15:AW], WrAddr[15:AW]};

    // Program image storage; not reset so a preloaded image survives rst.
    always_ff @(posedge clk) begin
        if (Wr) begin
            mem_q[WrAddr[DEPTH_LOG2:1]] <= WrData;
        end
    end

    // State, countdown and latched address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic: accept in IDLE/RESP, count down in WAIT, Rd ignored in WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (Rd) begin
                    addr_d  = Addr[AW-1:0];
                    cnt_d   = LAT_M1;
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                addr_d  = '0;
            end
        endcase
    end

    assign in_idle_s = (state_q == ST_IDLE);
    assign in_wait_s = (state_q == ST_WAIT);
    assign in_resp_s = (state_q == ST_RESP);
    // Read in the RESP cycle itself, so a write landing at the end of that
    // cycle is not seen, while earlier writes to the pending index are.
    assign rd_word_s = mem_q[addr_q[DEPTH_LOG2:1]];

    // Response outputs: word only on an even-address Done, zero otherwise.
    always_comb begin
        Done    = in_resp_s;
        Err     = 1'b0;
        DataOut = 16'h0000;
        if (in_resp_s) begin
            Err = addr_q[0];
            if (addr_q[0]) begin
                DataOut = 16'h0000;
            end else begin
                DataOut = rd_word_s;
            end
        end else begin
            Err     = 1'b0;
            DataOut = 16'h0000;
        end
    end

    // Stall covers the accept cycle and the wait cycles; forced low in reset.
    always_comb begin
        Stall = 1'b0;
        if (rst) begin
            Stall = (in_idle_s & Rd) | in_wait_s | (in_resp_s & Rd);
        end else begin
            Stall = 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder (DEPTH_LOG2=8, LATENCY=4).
// A vector table covers single reads (data, wrap, odd address); hand-written
// sequences cover back-to-back reads, reset mid-request and write races.
module tb_imem_responder;

    logic        clk;
    logic        rst;
    logic        Rd;
    logic [15:0] Addr;
    logic        Wr;
    logic [15:0] WrAddr;
    logic [15:0] WrData;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        Err;

    int total;
    int bad;

    imem_responder #(
        .DEPTH_LOG2(8),
        .LATENCY   (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .Rd     (Rd),
        .Addr   (Addr),
        .Wr     (Wr),
        .WrAddr (WrAddr),
        .WrData (WrData),
        .DataOut(DataOut),
        .Done   (Done),
        .Stall  (Stall),
        .Err    (Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] wa;
        logic [15:0] wd;
        logic [15:0] ra;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        Wr = 1'b1; WrAddr = a; WrData = d;
        step();
        Wr = 1'b0;
    endtask

    // One read issued in the current cycle; optional write at cycle offset wr_off.
    task automatic do_read(input string name, input logic [15:0] a,
                           input logic [15:0] exp_d, input logic exp_e,
                           input int wr_off, input logic [15:0] wa, input logic [15:0] wd);
        for (int k = 0; k <= 4; k++) begin
            Rd     = (k == 0);
            Addr   = a;
            Wr     = (k == wr_off);
            WrAddr = wa;
            WrData = wd;
            #1;
            if (k < 4) begin
                chk({name, " stall"}, {15'd0, Stall}, 16'd1);
                chk({name, " done_early"}, {15'd0, Done}, 16'd0);
            end else begin
                chk({name, " done"}, {15'd0, Done}, 16'd1);
                chk({name, " data"}, DataOut, exp_d);
                chk({name, " err"}, {15'd0, Err}, {15'd0, exp_e});
                chk({name, " stall_resp"}, {15'd0, Stall}, 16'd0);
            end
            step();
        end
        Wr = 1'b0;
        #1;
        chk({name, " done_after"}, {15'd0, Done}, 16'd0);
        chk({name, " data_after"}, DataOut, 16'h0000);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0; Rd = 1'b1; Addr = 16'h0010;
        Wr = 1'b0; WrAddr = 16'h0000; WrData = 16'h0000;

        vecs[0] = '{1'b1, 16'h0010, 16'hA5C3, 16'h0010, 16'hA5C3, 1'b0};
        vecs[1] = '{1'b1, 16'h0004, 16'hBEEF, 16'h0204, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b1, 16'h0006, 16'h1234, 16'h0003, 16'h0000, 1'b1};
        vecs[3] = '{1'b1, 16'h01FE, 16'h7E57, 16'h01FE, 16'h7E57, 1'b0};
        vecs[4] = '{1'b1, 16'hFF08, 16'hCAFE, 16'h0108, 16'hCAFE, 1'b0};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, 16'h0011, 16'h0000, 1'b1};

        // Reset state, with Rd held high to show Stall is forced low.
        step();
        step();
        #1;
        chk("rst stall", {15'd0, Stall}, 16'd0);
        chk("rst done", {15'd0, Done}, 16'd0);
        chk("rst err", {15'd0, Err}, 16'd0);
        chk("rst data", DataOut, 16'h0000);
        Rd = 1'b0;
        rst = 1'b1;
        step();

        // Idle inertness.
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("idle outs", {13'd0, Done, Stall, Err}, 16'd0);
            step();
        end

        // Table-driven single reads.
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].we) begin
                wr(vecs[i].wa, vecs[i].wd);
            end
            do_read($sformatf("vec%0d", i), vecs[i].ra, vecs[i].exp_data,
                    vecs[i].exp_err, -1, 16'h0000, 16'h0000);
        end

        // Back-to-back: second request accepted in the first Done cycle.
        wr(16'h0000, 16'h1111);
        wr(16'h0002, 16'h2222);
        Rd = 1'b1; Addr = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("b2b stall1", {15'd0, Stall}, 16'd1);
            chk("b2b done1_early", {15'd0, Done}, 16'd0);
            step();
        end
        Addr = 16'h0002;
        #1;
        chk("b2b done1", {15'd0, Done}, 16'd1);
        chk("b2b data1", DataOut, 16'h1111);
        step();
        Rd = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("b2b stall2", {15'd0, Stall}, 16'd1);
            chk("b2b done2_early", {15'd0, Done}, 16'd0);
            step();
        end
        #1;
        chk("b2b done2", {15'd0, Done}, 16'd1);
        chk("b2b data2", DataOut, 16'h2222);
        chk("b2b stall2_resp", {15'd0, Stall}, 16'd0);
        step();

        // Reset mid-request: request at t dropped, new request at t+5.
        Rd = 1'b1; Addr = 16'h0000;
        step();
        Rd = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("midrst stall", {15'd0, Stall}, 16'd0);
        chk("midrst done", {15'd0, Done}, 16'd0);
        step();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("midrst no_done", {15'd0, Done}, 16'd0);
            chk("midrst no_stall", {15'd0, Stall}, 16'd0);
            step();
        end
        do_read("postrst", 16'h0010, 16'hA5C3, 1'b0, -1, 16'h0000, 16'h0000);

        // Write race: write before RESP is seen, write during RESP is not.
        wr(16'h000A, 16'h0001);
        do_read("race_early", 16'h000A, 16'h0002, 1'b0, 2, 16'h000A, 16'h0002);
        wr(16'h000A, 16'h0001);
        do_read("race_resp", 16'h000A, 16'h0001, 1'b0, 4, 16'h000A, 16'h0002);
        do_read("race_after", 16'h000A, 16'h0002, 1'b0, -1, 16'h0000, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
